// File: rtl/mod_pkg.sv
// Shared types and elaboration helpers for the mod_reduce shift-subtract reducer.
package mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int width, input int steps);
        int w;
        w = $clog2(width / steps);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit cfg_ok(input int width, input int steps);
        return (width >= 2) && (steps >= 1) && (steps <= width) && ((width % steps) == 0);
    endfunction

endpackage

// File: rtl/mod_reduce_if.sv
// Operand/result handshake bundle for mod_reduce; quot exists only with MOD_REDUCE_QUOTIENT_EN.
// valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its data stable until then.
interface mod_reduce_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             div_zero;
`ifdef MOD_REDUCE_QUOTIENT_EN
    logic [WIDTH-1:0] quot;
`endif

    modport master (
        output in_valid, a, b, out_ready,
`ifdef MOD_REDUCE_QUOTIENT_EN
        input  quot,
`endif
        input  in_ready, out_valid, res, div_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef MOD_REDUCE_QUOTIENT_EN
        output quot,
`endif
        output in_ready, out_valid, res, div_zero
    );
endinterface

// File: rtl/mod_sub_stage.sv
// One restoring-division sub-step: shift in a dividend bit, subtract b if it fits.
module mod_sub_stage #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] t;

    // Compare at WIDTH+1 bits; the difference is always < b, so WIDTH-bit wrap subtraction is exact.
    always_comb begin
        t        = {rem, bit_in};
        q_bit    = (t >= {1'b0, b});
        rem_next = q_bit ? (t[WIDTH-1:0] - b) : t[WIDTH-1:0];
    end
endmodule

// File: rtl/mod_reduce.sv
// Fixed-latency a mod b by restoring long division, STEPS quotient bits per clock.
// Optional quotient output enabled by defining MOD_REDUCE_QUOTIENT_EN.
module mod_reduce
    import mod_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int STEPS = 1
) (
    input  logic           clk,
    input  logic           rst,
    mod_reduce_if.slave    bus,
    output state_e         dbg_state
);
    localparam int             ITERS    = WIDTH / STEPS;
    localparam int             CW       = cnt_width(WIDTH, STEPS);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(ITERS - 1);

    if (!cfg_ok(WIDTH, STEPS)) begin : g_cfg_err
        $error("mod_reduce: WIDTH must be >= 2 and divisible by STEPS");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             div_zero_q;
    logic             b_zero;
    logic             last_iter;

    logic [WIDTH-1:0] rem_chain [0:STEPS];
    logic [STEPS-1:0] q_bits;

    assign b_zero    = (bus.b == '0);
    assign last_iter = (cnt_q == '0);
    assign dbg_state = state_q;

    // Sub-step i consumes dividend bit WIDTH-1-i, so the first stage yields the group's top quotient bit.
    assign rem_chain[0] = rem_q;
    for (genvar i = 0; i < STEPS; i++) begin : g_stage
        mod_sub_stage #(.WIDTH(WIDTH)) u_stage (
            .rem      (rem_chain[i]),
            .bit_in   (a_q[WIDTH-1-i]),
            .b        (b_q),
            .rem_next (rem_chain[i+1]),
            .q_bit    (q_bits[STEPS-1-i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = b_zero ? DONE : BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // rem_q doubles as the result register: it only changes in IDLE/BUSY, so it is stable in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    cnt_q      <= CNT_LOAD;
                    div_zero_q <= b_zero;
                    rem_q      <= b_zero ? bus.a : '0;
                end
                BUSY: begin
                    a_q   <= a_q << STEPS;
                    rem_q <= rem_chain[STEPS];
                    cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.res      = rem_q;
    assign bus.div_zero = div_zero_q;

`ifdef MOD_REDUCE_QUOTIENT_EN
    logic [WIDTH-1:0] quot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) quot_q <= b_zero ? '1 : '0;
                BUSY: quot_q <= (quot_q << STEPS) | WIDTH'(q_bits);
                default: ;
            endcase
        end
    end

    assign bus.quot = quot_q;
`endif
endmodule

// File: tb/tb_mod_reduce.sv
// Directed-vector bench for mod_reduce at WIDTH=128/STEPS=1 and WIDTH=32/STEPS=4.
module tb_mod_reduce;
    import mod_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    state_e st128, st32;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    mod_reduce_if #(.WIDTH(128)) bus128 ();
    mod_reduce_if #(.WIDTH(32))  bus32 ();

    mod_reduce #(.WIDTH(128), .STEPS(1)) dut128 (
        .clk (clk), .rst (rst), .bus (bus128), .dbg_state (st128)
    );
    mod_reduce #(.WIDTH(32), .STEPS(4)) dut32 (
        .clk (clk), .rst (rst), .bus (bus32), .dbg_state (st32)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // cyc counts clock edges after the acceptance edge until out_valid is seen.
    task automatic run128(input logic [127:0] a_v, input logic [127:0] b_v,
                          input logic [127:0] exp_res, input logic [127:0] exp_quot,
                          input logic exp_dz, input int exp_lat);
        int cyc;
        logic [127:0] e;
        @(negedge clk);
        check("w128_in_ready", bus128.in_ready, 1);
        bus128.a = a_v; bus128.b = b_v; bus128.in_valid = 1'b1;
        exp_q.push_back(exp_res);
        @(posedge clk);
        @(negedge clk);
        bus128.in_valid = 1'b0;
        cyc = 0;
        while (!bus128.out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("w128_latency", cyc, exp_lat);
        e = exp_q.pop_front();
        check("w128_res", bus128.res, e);
        check("w128_div_zero", bus128.div_zero, exp_dz);
`ifdef MOD_REDUCE_QUOTIENT_EN
        check("w128_quot", bus128.quot, exp_quot);
`else
        if (exp_quot === 'x) $display("note: unreachable");
`endif
        @(negedge clk);
        check("w128_released", {bus128.out_valid, bus128.in_ready}, 2'b01);
    endtask

    task automatic run32(input logic [31:0] a_v, input logic [31:0] b_v,
                         input logic [31:0] exp_res, input logic [31:0] exp_quot,
                         input logic exp_dz, input int exp_lat);
        int cyc;
        logic [127:0] e;
        @(negedge clk);
        check("w32_in_ready", bus32.in_ready, 1);
        bus32.a = a_v; bus32.b = b_v; bus32.in_valid = 1'b1;
        exp_q.push_back({96'd0, exp_res});
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        cyc = 0;
        while (!bus32.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("w32_latency", cyc, exp_lat);
        e = exp_q.pop_front();
        check("w32_res", bus32.res, e);
        check("w32_div_zero", bus32.div_zero, exp_dz);
`ifdef MOD_REDUCE_QUOTIENT_EN
        check("w32_quot", bus32.quot, exp_quot);
`else
        if (exp_quot === 'x) $display("note: unreachable");
`endif
        @(negedge clk);
        check("w32_released", {bus32.out_valid, bus32.in_ready}, 2'b01);
    endtask

    initial begin
        logic [127:0] all1;
        logic [127:0] top1;
        int cyc;
        all1 = '1;
        top1 = 128'd1 << 127;

        bus128.in_valid = 1'b0; bus128.a = '0; bus128.b = '0; bus128.out_ready = 1'b1;
        bus32.in_valid  = 1'b0; bus32.a  = '0; bus32.b  = '0; bus32.out_ready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", st128, IDLE);
        check("rst_flags", {bus128.in_ready, bus128.out_valid, bus128.div_zero}, 3'b100);
        check("rst_res", bus128.res, 0);
        check("rst32_flags", {bus32.in_ready, bus32.out_valid, bus32.div_zero}, 3'b100);
`ifdef MOD_REDUCE_QUOTIENT_EN
        check("rst_quot", bus128.quot, 0);
`endif
        rst = 1'b0;

        // WIDTH=128, STEPS=1
        run128(128'd100, 128'd7, 128'd2, 128'd14, 1'b0, 128);
        run128(128'd5, 128'd9, 128'd5, 128'd0, 1'b0, 128);
        run128(all1, top1 + 128'd1, top1 - 128'd2, 128'd1, 1'b0, 128);
        run128(128'h1234, 128'd0, 128'h1234, all1, 1'b1, 0);
        run128(all1, 128'd1, 128'd0, all1, 1'b0, 128);
        run128(128'd1 << 64, (128'd1 << 64) - 128'd1, 128'd1, 128'd1, 1'b0, 128);
        run128(128'd0, 128'd5, 128'd0, 128'd0, 1'b0, 128);

        // WIDTH=32, STEPS=4
        run32(32'hFFFF_FFFF, 32'd10, 32'd5, 32'd429496729, 1'b0, 8);
        run32(32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, 8);
        run32(32'h8000_0001, 32'h8000_0001, 32'd0, 32'd1, 1'b0, 8);
        run32(32'hDEAD, 32'd0, 32'hDEAD, 32'hFFFF_FFFF, 1'b1, 0);

        // Backpressure: result held and new operands ignored while out_ready is low
        @(negedge clk);
        bus128.out_ready = 1'b0;
        bus128.a = 128'd100; bus128.b = 128'd7; bus128.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus128.in_valid = 1'b0;
        cyc = 0;
        while (!bus128.out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_latency", cyc, 128);
        bus128.a = 128'd55; bus128.b = 128'd3; bus128.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res_hold", bus128.res, 128'd2);
        end
        check("bp_flags", {bus128.out_valid, bus128.in_ready}, 2'b10);
        bus128.in_valid = 1'b0;
        bus128.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {bus128.out_valid, bus128.in_ready}, 2'b01);

        // Reset mid-computation
        bus128.a = 128'd100; bus128.b = 128'd7; bus128.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus128.in_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_busy", st128, BUSY);
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {bus128.out_valid, bus128.in_ready, bus128.div_zero}, 3'b010);
        check("mid_rst_res", bus128.res, 0);
        check("mid_rst_state", st128, IDLE);
`ifdef MOD_REDUCE_QUOTIENT_EN
        check("mid_rst_quot", bus128.quot, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run128(128'd100, 128'd7, 128'd2, 128'd14, 1'b0, 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
